// File: rtl/modadd_pkg.sv
// -----------------------------------------------------------------------------
// modadd_pkg
// Shared definitions for the modular add/subtract controller:
//   - WIDTH_DEF   : default operand/modulus width in bits
//   - TIMEOUT_DEF : default add_done watchdog limit in cycles
//   - state_t     : controller state encoding
// -----------------------------------------------------------------------------
package modadd_pkg;

    localparam int WIDTH_DEF   = 1027;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1_ISSUE,
        ST_P1_WAIT,
        ST_P2_ISSUE,
        ST_P2_WAIT,
        ST_FIN
    } state_t;

endpackage : modadd_pkg

// File: rtl/modadd_ctrl.sv
// -----------------------------------------------------------------------------
// modadd_ctrl
// Computes (a+b) mod m or (a-b) mod m by driving an external multi-precision
// adder (mpadder) through a start/done handshake, in one or two passes:
//   add : r1 = a+b, then r1-m; keep r1 if the second pass went negative.
//   sub : r1 = a-b; if negative, second pass r1+m.
// Operands must satisfy a, b < m < 2^(WIDTH-1).
//
// Ports
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   start, subtract      request pulse (sampled in IDLE) and operation select
//   in_a, in_b, in_m     operands and modulus
//   result, done, busy   registered result, one-cycle done pulse, busy flag
//   add_start, add_subtract, add_in_a, add_in_b   adder request side
//   add_result, add_done                          adder response side
//   err                  (MODADD_TIMEOUT_EN only) watchdog timeout pulse
//
// Configuration
//   MODADD_TIMEOUT_EN : when defined, a watchdog aborts a pass after TIMEOUT
//                       cycles without add_done, pulsing err with done and
//                       returning result 0. Undefined: waits indefinitely.
// -----------------------------------------------------------------------------
module modadd_ctrl
    import modadd_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done
`ifdef MODADD_TIMEOUT_EN
    ,
    output logic             err
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             add_start_q, add_start_d;
    logic             add_sub_q, add_sub_d;
    logic [WIDTH-1:0] add_in_a_q, add_in_a_d;
    logic [WIDTH-1:0] add_in_b_q, add_in_b_d;

`ifdef MODADD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        // NOTE: every _d starts from its held value so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        m_d         = m_q;
        sub_d       = sub_q;
        r1_d        = r1_q;
        result_d    = result_q;
        busy_d      = busy_q;
        add_sub_d   = add_sub_q;
        add_in_a_d  = add_in_a_q;
        add_in_b_d  = add_in_b_q;
        done_d      = 1'b0;
        add_start_d = 1'b0;
`ifdef MODADD_TIMEOUT_EN
        err_d = 1'b0;
        // Counts consecutive wait cycles; cleared whenever a pass is issued.
        cnt_d = (state_q == ST_P1_WAIT || state_q == ST_P2_WAIT) ?
                cnt_q + CNT_W'(1) : '0;
`endif

        // add_start and the operands are registered, so they are loaded on
        // the transition into an ISSUE state and are visible during it.
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d         = in_m;
                    sub_d       = subtract;
                    add_in_a_d  = in_a;
                    add_in_b_d  = in_b;
                    add_sub_d   = subtract;
                    add_start_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_P1_ISSUE;
                end
            end

            ST_P1_ISSUE: state_d = ST_P1_WAIT;

            ST_P1_WAIT: begin
                if (add_done) begin
                    r1_d = add_result[WIDTH-1:0];
                    if (!sub_q || add_result[WIDTH]) begin
                        // add: r1 - m; negative difference: r1 + m
                        add_in_a_d  = add_result[WIDTH-1:0];
                        add_in_b_d  = m_q;
                        add_sub_d   = !sub_q;
                        add_start_d = 1'b1;
                        state_d     = ST_P2_ISSUE;
                    end else begin
                        result_d = add_result[WIDTH-1:0];
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_FIN;
                    end
                end
`ifdef MODADD_TIMEOUT_EN
                else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_FIN;
                end
`endif
            end

            ST_P2_ISSUE: state_d = ST_P2_WAIT;

            ST_P2_WAIT: begin
                if (add_done) begin
                    // In add mode a negative r1-m means r1 was already < m.
                    result_d = (!sub_q && add_result[WIDTH]) ? r1_q
                                                             : add_result[WIDTH-1:0];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_FIN;
                end
`ifdef MODADD_TIMEOUT_EN
                else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_FIN;
                end
`endif
            end

            ST_FIN: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset too, so an operation aborted by
    // reset leaves no stale operands behind for the next start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            sub_q       <= 1'b0;
            r1_q        <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            add_start_q <= 1'b0;
            add_sub_q   <= 1'b0;
            add_in_a_q  <= '0;
            add_in_b_q  <= '0;
`ifdef MODADD_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            m_q         <= m_d;
            sub_q       <= sub_d;
            r1_q        <= r1_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            add_start_q <= add_start_d;
            add_sub_q   <= add_sub_d;
            add_in_a_q  <= add_in_a_d;
            add_in_b_q  <= add_in_b_d;
`ifdef MODADD_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign result       = result_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign add_start    = add_start_q;
    assign add_subtract = add_sub_q;
    assign add_in_a     = add_in_a_q;
    assign add_in_b     = add_in_b_q;
`ifdef MODADD_TIMEOUT_EN
    assign err          = err_q;
`endif

endmodule : modadd_ctrl

// File: tb/tb_modadd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_modadd_ctrl
// Self-checking bench for modadd_ctrl (WIDTH=1027). A behavioural mpadder
// answers each add_start with add_done six cycles later. Table-driven
// vectors cover the add/sub paths; hand-written sequences cover ignored
// start/add_done pulses, reset mid-operation and (MODADD_TIMEOUT_EN) the
// watchdog.
// -----------------------------------------------------------------------------
module tb_modadd_ctrl;

    localparam int W   = 1027;
    localparam int LAT = 6;
    localparam int TO  = 64;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] in_m = '0;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         add_start;
    logic         add_subtract;
    logic [W-1:0] add_in_a;
    logic [W-1:0] add_in_b;
    logic [W:0]   add_result = '0;
    logic         add_done;
    logic         model_done = 1'b0;
    logic         spur_done = 1'b0;
`ifdef MODADD_TIMEOUT_EN
    logic         err;
`endif

    assign add_done = model_done | spur_done;

    modadd_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .subtract     (subtract),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .result       (result),
        .done         (done),
        .busy         (busy),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
`ifdef MODADD_TIMEOUT_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mpadder model ----------------
    int           mcnt = 0;
    int           n_starts = 0;
    int           stab_err = 0;
    int           ad_cyc = 0;
    int           st_cyc = 0;
    bit           withhold = 1'b0;
    logic [W-1:0] cap_a = '0;
    logic [W-1:0] cap_b = '0;
    logic         cap_sub = 1'b0;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (!resetn) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                if (add_in_a !== cap_a || add_in_b !== cap_b || add_subtract !== cap_sub)
                    stab_err++;
                mcnt--;
                if (mcnt == 0 && !withhold) begin
                    model_done = 1'b1;
                    add_result = cap_sub ? ({1'b0, cap_a} - {1'b0, cap_b})
                                         : ({1'b0, cap_a} + {1'b0, cap_b});
                    ad_cyc = cyc;
                end
            end
            if (add_start === 1'b1) begin
                n_starts++;
                cap_a   = add_in_a;
                cap_b   = add_in_b;
                cap_sub = add_subtract;
                mcnt    = LAT;
                st_cyc  = cyc;
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m, input logic sub,
                          input logic [31:0] exp_res, input int exp_passes);
        int base_st;
        int base_err;
        bit got;
        base_st  = n_starts;
        base_err = stab_err;
        @(negedge clk);
        in_a     = W'(a);
        in_b     = W'(b);
        in_m     = W'(m);
        subtract = sub;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, (W+1)'(busy), (W+1)'(1));
        wait_done(200, got);
        check({tag, "_done_seen"}, (W+1)'(got), (W+1)'(1));
        if (got) begin
            check({tag, "_result"}, (W+1)'(result), (W+1)'(exp_res));
            check({tag, "_done_lat"}, (W+1)'(cyc - ad_cyc), (W+1)'(1));
            check({tag, "_busy_fin"}, (W+1)'(busy), (W+1)'(0));
            check({tag, "_passes"}, (W+1)'(n_starts - base_st), (W+1)'(exp_passes));
            check({tag, "_stable"}, (W+1)'(stab_err - base_err), (W+1)'(0));
`ifdef MODADD_TIMEOUT_EN
            check({tag, "_err"}, (W+1)'(err), (W+1)'(0));
`endif
            @(negedge clk);
            check({tag, "_done_pulse"}, (W+1)'(done), (W+1)'(0));
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic        sub;
        logic [31:0] res;
        int          passes;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        int  base_st;
        int  base_err;
        int  extra;
        bit  got;

        vecs[0] = '{32'd5,     32'd7,     32'd13,    1'b0, 32'd12,    2};
        vecs[1] = '{32'd9,     32'd8,     32'd13,    1'b0, 32'd4,     2};
        vecs[2] = '{32'd0,     32'd0,     32'd13,    1'b0, 32'd0,     2};
        vecs[3] = '{32'd6,     32'd7,     32'd13,    1'b0, 32'd0,     2};  // a+b == m
        vecs[4] = '{32'd12,    32'd12,    32'd13,    1'b0, 32'd11,    2};
        vecs[5] = '{32'd3,     32'd10,    32'd13,    1'b1, 32'd6,     2};
        vecs[6] = '{32'd10,    32'd3,     32'd13,    1'b1, 32'd7,     1};
        vecs[7] = '{32'd7,     32'd7,     32'd13,    1'b1, 32'd0,     1};  // a == b
        vecs[8] = '{32'd0,     32'd12,    32'd13,    1'b1, 32'd1,     2};
        vecs[9] = '{32'd65000, 32'd64999, 32'd65001, 1'b0, 32'd64998, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_result", (W+1)'(result), '0);
        check("rst_done", (W+1)'(done), '0);
        check("rst_busy", (W+1)'(busy), '0);
        check("rst_add_start", (W+1)'(add_start), '0);
        check("rst_add_in_a", (W+1)'(add_in_a), '0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m,
                   vecs[i].sub, vecs[i].res, vecs[i].passes);

        // start pulsed in P1_WAIT and in FIN must be ignored
        base_st  = n_starts;
        base_err = stab_err;
        @(negedge clk);
        in_a = W'(5); in_b = W'(7); in_m = W'(13); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        in_a = W'(1); in_b = W'(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, got);
        check("ign_done_seen", (W+1)'(got), (W+1)'(1));
        check("ign_result", (W+1)'(result), (W+1)'(12));
        in_a = W'(2); in_b = W'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) extra++;
            @(negedge clk);
        end
        check("ign_extra_done", (W+1)'(extra), (W+1)'(0));
        check("ign_passes", (W+1)'(n_starts - base_st), (W+1)'(2));
        check("ign_stable", (W+1)'(stab_err - base_err), (W+1)'(0));
        check("ign_result_hold", (W+1)'(result), (W+1)'(12));

        // add_done in IDLE must be ignored
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        check("spur_no_done", (W+1)'(extra), (W+1)'(0));
        check("spur_result", (W+1)'(result), (W+1)'(12));

        // reset during P2_WAIT
        base_st = n_starts;
        @(negedge clk);
        in_a = W'(5); in_b = W'(7); in_m = W'(13); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_starts - base_st == 2) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst2_reached_p2", (W+1)'(got), (W+1)'(1));
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("rst2_result", (W+1)'(result), '0);
        check("rst2_done", (W+1)'(done), '0);
        check("rst2_busy", (W+1)'(busy), '0);
        check("rst2_add_start", (W+1)'(add_start), '0);
        check("rst2_add_sub", (W+1)'(add_subtract), '0);
        check("rst2_add_in_a", (W+1)'(add_in_a), '0);
        check("rst2_add_in_b", (W+1)'(add_in_b), '0);
        resetn = 1'b1;
        @(negedge clk);
        run_op("post_rst", 32'd1, 32'd1, 32'd13, 1'b0, 32'd2, 2);

`ifdef MODADD_TIMEOUT_EN
        // withheld add_done -> watchdog
        withhold = 1'b1;
        @(negedge clk);
        in_a = W'(5); in_b = W'(7); in_m = W'(13); subtract = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, got);
        check("to_done_seen", (W+1)'(got), (W+1)'(1));
        if (got) begin
            check("to_err", (W+1)'(err), (W+1)'(1));
            check("to_result", (W+1)'(result), '0);
            check("to_busy", (W+1)'(busy), '0);
            check("to_latency", (W+1)'(cyc - st_cyc), (W+1)'(TO + 1));
            @(negedge clk);
            check("to_err_pulse", (W+1)'(err), '0);
        end
        withhold = 1'b0;
        repeat (10) @(negedge clk);
        run_op("after_to", 32'd3, 32'd10, 32'd13, 1'b1, 32'd6, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_modadd_ctrl

// File: doc/modadd_ctrl.md
MODADD_CTRL -- requirements
Module: modadd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1027, operand/modulus width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 64, add_done watchdog limit in cycles (used only under REQ-025).
REQ-003 clk  input  1  sole clock, rising edge; one clock; all state on clk.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse, sampled in IDLE only.
REQ-006 subtract  input  1  0: (a+b) mod m; 1: (a-b) mod m.
REQ-007 in_a, in_b, in_m  input  WIDTH each  operands and modulus; requires a,b < m < 2^(WIDTH-1).
REQ-008 result  output  WIDTH  modular result, registered.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high from the cycle after accepted start until done.
REQ-011 add_start, add_subtract  output  1 each  initiator side of the mpadder start/done handshake.
REQ-012 add_in_a, add_in_b  output  WIDTH each  adder operands, registered.
REQ-013 add_result  input  WIDTH+1  adder result; in subtract mode (x-y) mod 2^(WIDTH+1), bit WIDTH = negative.
REQ-014 add_done  input  1  adder completion pulse; add_result valid in that cycle.

Function
REQ-015 States IDLE, P1_ISSUE, P1_WAIT, P2_ISSUE, P2_WAIT, FIN; one-hot or binary encoding is unconstrained.
REQ-016 IDLE & start: latch in_a, in_b, in_m, subtract; go to P1_ISSUE; start in any other state is ignored.
REQ-017 P1_ISSUE (one cycle): add_start=1, add_in_a=a, add_in_b=b, add_subtract=subtract; then P1_WAIT.
REQ-018 P1_WAIT on add_done: latch r1=add_result; add mode -> P2_ISSUE with (r1[WIDTH-1:0] - m); sub mode: r1[WIDTH]=1 -> P2_ISSUE with (r1[WIDTH-1:0] + m), else result<=r1[WIDTH-1:0], FIN.
REQ-019 P2_WAIT on add_done: add mode result <= add_result[WIDTH]? r1 : add_result[WIDTH-1:0]; sub mode result <= add_result[WIDTH-1:0]; go FIN.
REQ-020 FIN: done=1 for exactly one cycle, then IDLE; done asserts 1 cycle after the final add_done.
REQ-021 add_start SHALL be high exactly one cycle per pass; add_in_a/add_in_b/add_subtract held stable from add_start until the matching add_done.
REQ-022 add_done received in IDLE, FIN or *_ISSUE SHALL be ignored.
REQ-023 result SHALL hold its value until the next done; busy=0 in IDLE and FIN.

Reset
REQ-024 resetn low (any time, including mid-pass): state=IDLE, result=0, done=0, busy=0, add_start=0, add_subtract=0, add_in_a=0, add_in_b=0, internal regs 0; the next accepted start begins a fresh operation.

Configuration
REQ-025 MODADD_TIMEOUT_EN defined: output err (1 bit) added; cycle counter in *_WAIT; TIMEOUT cycles without add_done -> err=1 pulse with done=1, result=0, then IDLE. Undefined: no err port, no counter; waits indefinitely.

Structure
REQ-026 Package modadd_pkg SHALL hold the state enum typedef, WIDTH default, TIMEOUT default.
REQ-027 No sub-module; mpadder is instantiated alongside by the integrating top, not inside.

Verification (bench models mpadder with latency 6 cycles, WIDTH=1027)
REQ-028 a=5,b=7,m=13,subtract=0 -> two passes, result=12, done one cycle after 2nd add_done.
REQ-029 a=9,b=8,m=13,subtract=0 -> result=4; a=0,b=0 -> result=0.
REQ-030 a=3,b=10,m=13,subtract=1 -> second pass add m, result=6; a=10,b=3 -> single pass, result=7, add_start pulsed once.
REQ-031 start pulsed again in P1_WAIT and FIN -> ignored, single done, operands unchanged.
REQ-032 resetn low during P2_WAIT -> all outputs 0 next edge; subsequent start a=1,b=1,m=13 -> result=2.
REQ-033 With MODADD_TIMEOUT_EN, model withholds add_done -> err=1 and done=1 after 64 cycles, result=0, busy=0.
